// File: rtl/fetch_defs.sv
// Shared definitions for the instruction fetch stage: NOP encoding, default
// halt word, FSM state encoding and the next-PC select used by the PC register.
package fetch_defs;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // Fetch addresses are always word aligned; stray low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC mux (redirect / hold / +4).
// Redirect targets are forced to word alignment; +4 wraps modulo 2^32.
module fetch_pc_reg
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     sel,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    // Select the PC for the next edge.
    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:      pc_next = pc + 32'd4;
            PC_REDIRECT: pc_next = align_word(redirect_pc);
            default:     pc_next = pc;
        endcase
    end

    // PC state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, drives the combinational instruction memory and
// captures the returned word into the IF/ID register. Honours stall, redirect
// from EX, and stops on the halt word or an out-of-range PC.
// Optional macro FETCH_PERF_EN adds saturating fetch / stall-cycle counters.
module instr_fetch_unit
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 32,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic        fault
);

    fetch_state_e state;
    pc_sel_e      pc_sel;
    logic         range_fault;
    logic         halt_hit;
    logic         fetch_load;

    assign imem_addr = pc;

    // Word index beyond the memory faults regardless of what the bus returns.
    assign range_fault = ({2'b00, pc[31:2]} >= IMEM_DEPTH);
    assign halt_hit    = (imem_data == HALT_WORD) || range_fault;
    assign fetch_load  = (state == ST_RUN) && !redirect_valid && !stall && !halt_hit;

    // Next-PC select; priority redirect > stall > halt detect > increment.
    always_comb begin
        pc_sel = PC_HOLD;
        if (redirect_valid) begin
            pc_sel = PC_REDIRECT;
        end else if (state == ST_RUN && !stall && !halt_hit) begin
            pc_sel = PC_INC;
        end
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (CLK),
        .rst         (RST),
        .sel         (pc_sel),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    // Fetch FSM with registered IF/ID, halted and fault outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_RUN;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'h0000_0000;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
            fault          <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (redirect_valid) begin
                        if_id_instr    <= NOP_WORD;
                        if_id_pc_plus4 <= 32'h0000_0000;
                        if_id_valid    <= 1'b0;
                    end else if (stall) begin
                        // Hold everything.
                    end else if (halt_hit) begin
                        state          <= ST_HALT;
                        halted         <= 1'b1;
                        fault          <= range_fault;
                        if_id_instr    <= NOP_WORD;
                        if_id_pc_plus4 <= 32'h0000_0000;
                        if_id_valid    <= 1'b0;
                    end else begin
                        if_id_instr    <= imem_data;
                        if_id_pc_plus4 <= pc + 32'd4;
                        if_id_valid    <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if_id_instr    <= NOP_WORD;
                    if_id_pc_plus4 <= 32'h0000_0000;
                    if_id_valid    <= 1'b0;
                    // An older in-flight branch cancels a speculative halt.
                    if (redirect_valid) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                        fault  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating performance counters; both naturally freeze in HALT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched      <= 32'h0000_0000;
            perf_stall_cycles <= 32'h0000_0000;
        end else begin
            if (fetch_load && perf_fetched != 32'hFFFF_FFFF) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (state == ST_RUN && stall && !redirect_valid &&
                perf_stall_cycles != 32'hFFFF_FFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// randomized stall/redirect/reset traffic against a behavioural model.
module tb_instr_fetch_unit;

    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr, imem_data, pc, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, halted, fault;

    logic        RST4 = 1'b1;
    logic [31:0] imem_addr4, imem_data4, pc4, if_id_instr4, if_id_pc_plus44;
    logic        if_id_valid4, halted4, fault4;

    logic [31:0] mem [0:63];

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted, m_fault;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall_cycles, perf_fetched4, perf_stall_cycles4;
`endif

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx < 64) return mem[idx[5:0]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb imem_data  = mem_word(imem_addr);
    always_comb imem_data4 = mem_word(imem_addr4);

    instr_fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_DEPTH (32),
        .HALT_WORD  (HALTW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
`ifdef FETCH_PERF_EN
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .fault          (fault)
    );

    instr_fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_DEPTH (4),
        .HALT_WORD  (HALTW)
    ) dut4 (
        .CLK            (CLK),
        .RST            (RST4),
        .imem_addr      (imem_addr4),
        .imem_data      (imem_data4),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .pc             (pc4),
        .if_id_instr    (if_id_instr4),
        .if_id_pc_plus4 (if_id_pc_plus44),
        .if_id_valid    (if_id_valid4),
        .halted         (halted4),
`ifdef FETCH_PERF_EN
        .perf_fetched      (perf_fetched4),
        .perf_stall_cycles (perf_stall_cycles4),
`endif
        .fault          (fault4)
    );

    // Advance the model by one edge from the currently applied inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] word;
        logic        out_of_range;
        word = mem_word(m_pc);
        out_of_range = (m_pc / 4) >= 32;
        if (RST) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0; m_fault = 0;
        end else if (m_halted) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (redirect_valid) begin
                m_halted = 0; m_fault = 0; m_pc = redirect_pc & ~32'd3;
            end
        end else if (redirect_valid) begin
            m_pc = redirect_pc & ~32'd3;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (stall) begin
            // nothing changes
        end else if (word == HALTW || out_of_range) begin
            m_halted = 1; m_fault = out_of_range;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            m_instr = word; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1; stall = 0; redirect_valid = 0;
        tick(); tick();
        vectors++;
        if ({imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fault} !==
            {32'h0, 32'h0, 32'h0, 32'h0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset: got pc=%h instr=%h pc4=%h v=%b h=%b f=%b, want all zero",
                     pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fault);
        end
        RST = 0;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_instr [2];
        exp_instr[0] = 32'h2008_0001;
        exp_instr[1] = 32'h2009_0002;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({if_id_instr, if_id_pc_plus4, pc, if_id_valid} !==
                {exp_instr[i], 32'(4 * (i + 1)), 32'(4 * (i + 1)), 1'b1}) begin
                miscompares++;
                $display("FAIL free_run[%0d]: got instr=%h pc4=%h pc=%h v=%b want %h/%h/%h/1",
                         i, if_id_instr, if_id_pc_plus4, pc, if_id_valid,
                         exp_instr[i], 4 * (i + 1), 4 * (i + 1));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !==
                {32'd8, 32'h2009_0002, 32'd8, 1'b1}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got pc=%h instr=%h pc4=%h v=%b want 8/20090002/8/1",
                         i, pc, if_id_instr, if_id_pc_plus4, if_id_valid);
            end
        end
        stall = 0;
        tick();
        vectors++;
        if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {32'd12, 32'h0, 32'd12, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_resume: got pc=%h instr=%h pc4=%h v=%b want c/0/c/1",
                     pc, if_id_instr, if_id_pc_plus4, if_id_valid);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1; redirect_valid = 1; redirect_pc = 32'h0000_0006;
        tick();
        stall = 0; redirect_valid = 0;
        vectors++;
        if ({pc, if_id_valid, if_id_instr} !== {32'h4, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL redirect_stall: got pc=%h v=%b instr=%h want 4/0/0",
                     pc, if_id_valid, if_id_instr);
        end
        tick();
        vectors++;
        if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !==
            {32'h8, 32'h2009_0002, 32'h8, 1'b1}) begin
            miscompares++;
            $display("FAIL redirect_refetch: got pc=%h instr=%h pc4=%h v=%b want 8/20090002/8/1",
                     pc, if_id_instr, if_id_pc_plus4, if_id_valid);
        end
    endtask

    task automatic test_halt_word();
        // pc=8 now: fetch words 2,3,4 then the halt word at index 5.
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if ({halted, fault, pc, if_id_valid, if_id_instr} !==
                {1'b1, 1'b0, 32'd20, 1'b0, 32'h0}) begin
                miscompares++;
                $display("FAIL halt_word[%0d]: got h=%b f=%b pc=%h v=%b want 1/0/14/0",
                         i, halted, fault, pc, if_id_valid);
            end
            stall = $urandom_range(0, 1);
            if (i < 10) tick();
        end
        stall = 0;
    endtask

    task automatic test_halt_redirect();
        redirect_valid = 1; redirect_pc = 32'h8;
        tick();
        redirect_valid = 0;
        vectors++;
        if ({halted, fault, pc, if_id_valid} !== {1'b0, 1'b0, 32'h8, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_redirect: got h=%b f=%b pc=%h v=%b want 0/0/8/0",
                     halted, fault, pc, if_id_valid);
        end
        tick();
        vectors++;
        if ({pc, if_id_instr, if_id_valid} !== {32'hC, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL halt_resume: got pc=%h instr=%h v=%b want c/0/1",
                     pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_range_fault();
        RST4 = 1;
        tick();
        RST4 = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            vectors++;
            if ({pc4, halted4, if_id_valid4, if_id_instr4} !==
                {32'(4 * i), 1'b0, 1'b1, mem[i - 1]}) begin
                miscompares++;
                $display("FAIL range_run[%0d]: got pc=%h h=%b v=%b instr=%h want %h/0/1/%h",
                         i, pc4, halted4, if_id_valid4, if_id_instr4, 4 * i, mem[i - 1]);
            end
        end
        tick();
        vectors++;
        if ({halted4, fault4, pc4, if_id_valid4} !== {1'b1, 1'b1, 32'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL range_fault: got h=%b f=%b pc=%h v=%b want 1/1/10/0",
                     halted4, fault4, pc4, if_id_valid4);
        end
    endtask

    task automatic test_reset_mid_run();
        redirect_valid = 1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 0;
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (pc !== 32'd12) begin
            miscompares++;
            $display("FAIL reset_mid_setup: got pc=%h want c", pc);
        end
        RST = 1;
        tick();
        RST = 0;
        vectors++;
        if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fault} !==
            {32'h0, 32'h0, 32'h0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_mid: got pc=%h instr=%h pc4=%h v=%b h=%b f=%b want zeros",
                     pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fault);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) begin
            mem[i] = ($urandom_range(0, 9) == 0) ? HALTW : $urandom;
        end
        for (int n = 0; n < 600; n++) begin
            RST = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom_range(0, 150);
            tick();
            vectors++;
            if ({imem_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fault} !==
                {m_pc, m_pc, m_instr, m_pc4, m_valid, m_halted, m_fault}) begin
                miscompares++;
                $display("FAIL random[%0d]: got pc=%h instr=%h pc4=%h v=%b h=%b f=%b want %h/%h/%h/%b/%b/%b",
                         n, pc, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fault,
                         m_pc, m_instr, m_pc4, m_valid, m_halted, m_fault);
            end
        end
        RST = 0; stall = 0; redirect_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + i;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0000_0000;
        mem[3] = 32'h1111_1111;
        mem[4] = 32'h2222_2222;
        mem[5] = HALTW;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_halt_word();
        test_halt_redirect();
        test_range_fault();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF stage of the pipelined MIPS core.
- Owns the PC and drives the word address into the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Honours stall from hazard detection, redirect (branch/jump) from EX, and stops fetching on the halt word or an out-of-range PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 32, number of 32-bit words in instruction memory; fetches at word index >= IMEM_DEPTH fault.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that terminates fetch.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals pc, combinational.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  hold PC and IF/ID this cycle.
- redirect_valid  input  1  load redirect_pc; squash the IF/ID contents.
- redirect_pc  input  32  branch/jump target (byte address).
- pc  output  32  current fetch PC.
- if_id_instr  output  32  registered instruction.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped (HALT state).
- fault  output  1  halt caused by out-of-range PC, not by HALT_WORD.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST), sampled on the rising edge of CLK.
- Reset values:
  - pc = RESET_PC.
  - if_id_instr = 32'h0000_0000 (NOP), if_id_pc_plus4 = 0, if_id_valid = 0.
  - halted = 0, fault = 0, state = RUN.
- Fetch latency: the word at pc appears on if_id_instr one edge after pc is presented.
- States are RUN and HALT.
- Per-edge priority in RUN: RST > redirect_valid > stall > halt detect > normal.
  - redirect_valid=1:
    - pc <= {redirect_pc[31:2],2'b00}; low bits are silently forced to 0.
    - IF/ID <= NOP, valid=0. This also applies when stall=1 in the same cycle.
  - stall=1 (no redirect): pc and all IF/ID outputs hold unchanged.
  - imem_data==HALT_WORD, or (pc>>2)>=IMEM_DEPTH:
    - state <= HALT, pc holds, IF/ID <= NOP, valid=0.
    - fault <= 1 only for the range case; both conditions true reports fault=1.
  - Normal:
    - if_id_instr <= imem_data, if_id_pc_plus4 <= pc+4, valid <= 1.
    - pc <= pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- HALT state:
  - halted=1; pc frozen; IF/ID forced NOP/valid=0 every edge; stall ignored.
  - redirect_valid=1 (an older in-flight branch cancels a speculative halt):
    - state <= RUN, halted <= 0, fault <= 0, pc <= redirect target.
    - IF/ID stays NOP for that edge.
  - Only RST or redirect leaves HALT.
- halted and fault are registered; they assert on the edge that enters HALT.
- imem_addr is purely combinational from pc; there is no handshake with memory (always ready).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall_cycles[31:0], both reset to 0.
  - perf_fetched increments on every edge that loads if_id_valid=1.
  - perf_stall_cycles increments on every RUN edge with stall=1 and redirect_valid=0.
  - Both saturate at 32'hFFFF_FFFF and freeze in HALT.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Shared header/package `fetch_defs`: NOP_WORD, state encodings (ST_RUN=1'b0, ST_HALT=1'b1), and the default HALT_WORD constant.
- One natural sub-module: fetch_pc_reg, which holds the PC register with next-PC mux (redirect / hold / +4) and alignment forcing.
- State control and IF/ID stay in the top.

Test Plan:
- Reset then free run, imem words 0x20080001, 0x20090002, NOP: if_id_instr sequence 0x20080001, 0x20090002 with pc_plus4 4, 8; pc = 0,4,8,12.
- stall held 3 cycles at pc=8: pc stays 8, IF/ID unchanged for 3 edges, then resumes with word at 8.
- Redirect and stall in the same cycle at pc=12, redirect_pc=0x0000_0006: pc becomes 0x4, if_id_valid=0 on that edge, then fetches word 1.
- HALT_WORD at index 5 (pc=20): halted=1, fault=0, pc stays 20, if_id_valid=0 for 10 cycles; stall pulses have no effect.
- In HALT, redirect_valid with redirect_pc=0x8: halted=0 next edge, pc=8, fetch resumes.
- IMEM_DEPTH=4 with no halt word, run to pc=16: halted=1, fault=1. Separately, RST asserted mid-run at pc=12 restores all reset values on the next edge.
